// File: rtl/vga_board_scan.sv
// vga_board_scan: VGA raster scan, sync and board-cell counters. The o_border flag is built only when VGA_BOARD_BORDER_EN is defined; otherwise it is tied to 0.
module vga_board_scan #(
    parameter int H_ACTIVE     = 640,
    parameter int H_FP         = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BP         = 48,
    parameter int V_ACTIVE     = 480,
    parameter int V_FP         = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BP         = 33,
    parameter int CELL_SHIFT   = 4,
    parameter int PIX_DIV      = 1,
    parameter int BOARD_WIDTH  = 40,
    parameter int BOARD_HEIGHT = 30
) (
    input  logic       clk,
    input  logic       i_rst,
    output logic       o_pix_en,
    output logic [9:0] o_col_counter,
    output logic [9:0] o_row_counter,
    output logic [5:0] o_col_counter_div,
    output logic [5:0] o_row_counter_div,
    output logic       o_active,
    output logic       o_hsync,
    output logic       o_vsync,
    output logic       o_frame_start,
    output logic       o_border
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_BEG  = H_ACTIVE + H_FP;
    localparam int HS_END  = HS_BEG + H_SYNC;
    localparam int VS_BEG  = V_ACTIVE + V_FP;
    localparam int VS_END  = VS_BEG + V_SYNC;

    logic [3:0] div;
    logic [9:0] col_nx, row_nx;
    logic [5:0] cdiv_nx, rdiv_nx;
    logic       col_wrap, row_wrap, act_nx;

    // Everything below is the state presented after the next pixel advance.
    assign o_pix_en = div == 4'(PIX_DIV - 1);
    assign col_wrap = o_col_counter == 10'(H_TOTAL - 1);
    assign row_wrap = o_row_counter == 10'(V_TOTAL - 1);
    assign col_nx   = col_wrap ? 10'd0 : o_col_counter + 10'd1;
    assign row_nx   = !col_wrap ? o_row_counter : row_wrap ? 10'd0 : o_row_counter + 10'd1;
    assign act_nx   = (col_nx < 10'(H_ACTIVE)) && (row_nx < 10'(V_ACTIVE));
    assign cdiv_nx  = act_nx ? 6'(col_nx >> CELL_SHIFT) : 6'h3F;
    assign rdiv_nx  = act_nx ? 6'(row_nx >> CELL_SHIFT) : 6'h3F;

    // Pixel-clock divider: wraps after PIX_DIV system clocks.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) div <= 4'd0;
        else       div <= o_pix_en ? 4'd0 : div + 4'd1;
    end

    // Counters and decoded outputs advance together so they never skew.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            o_col_counter     <= 10'd0;
            o_row_counter     <= 10'd0;
            o_col_counter_div <= 6'd0;
            o_row_counter_div <= 6'd0;
            o_active          <= 1'b1;
            o_hsync           <= 1'b1;
            o_vsync           <= 1'b1;
            o_frame_start     <= 1'b0;
        end else if (o_pix_en) begin
            o_col_counter     <= col_nx;
            o_row_counter     <= row_nx;
            o_col_counter_div <= cdiv_nx;
            o_row_counter_div <= rdiv_nx;
            o_active          <= act_nx;
            o_hsync           <= !((col_nx >= 10'(HS_BEG)) && (col_nx < 10'(HS_END)));
            o_vsync           <= !((row_nx >= 10'(VS_BEG)) && (row_nx < 10'(VS_END)));
            o_frame_start     <= col_wrap && row_wrap;
        end
    end

`ifdef VGA_BOARD_BORDER_EN
    logic edge_nx;
    assign edge_nx = act_nx && (cdiv_nx == 6'd0 || cdiv_nx == 6'(BOARD_WIDTH - 1) ||
                                rdiv_nx == 6'd0 || rdiv_nx == 6'(BOARD_HEIGHT - 1));

    // Board-edge flag, registered in step with the div counters.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst)         o_border <= 1'b0;
        else if (o_pix_en) o_border <= edge_nx;
    end
`else
    assign o_border = 1'b0;
`endif
endmodule

// File: tb/tb_vga_board_scan.sv
// tb_vga_board_scan: three scan generators (small timing at 1 and 4 clocks/pixel, default timing) checked every cycle against an arithmetic model, with random async resets.
module tb_vga_board_scan;
    localparam int HA = 64, HF = 4, HS = 8, HB = 4;
    localparam int VA = 48, VF = 2, VS = 2, VB = 3;
    localparam int CS = 3, BW = 8, BH = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    logic       a_pen, a_act, a_hs, a_vs, a_fs, a_bd;
    logic [9:0] a_col, a_row;
    logic [5:0] a_cd, a_rd;
    logic       b_pen, b_act, b_hs, b_vs, b_fs, b_bd;
    logic [9:0] b_col, b_row;
    logic [5:0] b_cd, b_rd;
    logic       c_pen, c_act, c_hs, c_vs, c_fs, c_bd;
    logic [9:0] c_col, c_row;
    logic [5:0] c_cd, c_rd;

    vga_board_scan #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB), .V_ACTIVE(VA), .V_FP(VF),
        .V_SYNC(VS), .V_BP(VB), .CELL_SHIFT(CS), .PIX_DIV(1), .BOARD_WIDTH(BW), .BOARD_HEIGHT(BH)) dut_a (
        .clk(clk), .i_rst(rst), .o_pix_en(a_pen), .o_col_counter(a_col), .o_row_counter(a_row),
        .o_col_counter_div(a_cd), .o_row_counter_div(a_rd), .o_active(a_act), .o_hsync(a_hs),
        .o_vsync(a_vs), .o_frame_start(a_fs), .o_border(a_bd));

    vga_board_scan #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB), .V_ACTIVE(VA), .V_FP(VF),
        .V_SYNC(VS), .V_BP(VB), .CELL_SHIFT(CS), .PIX_DIV(4), .BOARD_WIDTH(BW), .BOARD_HEIGHT(BH)) dut_b (
        .clk(clk), .i_rst(rst), .o_pix_en(b_pen), .o_col_counter(b_col), .o_row_counter(b_row),
        .o_col_counter_div(b_cd), .o_row_counter_div(b_rd), .o_active(b_act), .o_hsync(b_hs),
        .o_vsync(b_vs), .o_frame_start(b_fs), .o_border(b_bd));

    vga_board_scan dut_c (
        .clk(clk), .i_rst(rst), .o_pix_en(c_pen), .o_col_counter(c_col), .o_row_counter(c_row),
        .o_col_counter_div(c_cd), .o_row_counter_div(c_rd), .o_active(c_act), .o_hsync(c_hs),
        .o_vsync(c_vs), .o_frame_start(c_fs), .o_border(c_bd));

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at n=%0d t=%0t", tag, got, exp, n, $time);
        end
    endtask

    // Expected scan state after n clock edges since reset: n/pd pixel advances.
    task automatic scan_model(input string t, input int pd, ha, hf, hs, hb, va, vf, vs, vb, cs, bw, bh,
                              input int pen, col, row, cd, rd, act, hsn, vsn, fs, bd);
        int ht = ha + hf + hs + hb;
        int vt = va + vf + vs + vb;
        int p = n / pd;
        int c = p % ht;
        int r = (p / ht) % vt;
        int e_act = (c < ha && r < va) ? 1 : 0;
        int e_cd = e_act ? (c >> cs) % 64 : 63;
        int e_rd = e_act ? (r >> cs) % 64 : 63;
        int e_bd = 0;
`ifdef VGA_BOARD_BORDER_EN
        e_bd = (p > 0 && e_act && (e_cd == 0 || e_cd == bw - 1 || e_rd == 0 || e_rd == bh - 1)) ? 1 : 0;
`endif
        check({t, ".pix_en"}, pen, (n % pd == pd - 1) ? 1 : 0);
        check({t, ".col"}, col, c);
        check({t, ".row"}, row, r);
        check({t, ".col_div"}, cd, e_cd);
        check({t, ".row_div"}, rd, e_rd);
        check({t, ".active"}, act, e_act);
        check({t, ".hsync"}, hsn, (c >= ha + hf && c < ha + hf + hs) ? 0 : 1);
        check({t, ".vsync"}, vsn, (r >= va + vf && r < va + vf + vs) ? 0 : 1);
        check({t, ".frame_start"}, fs, (p > 0 && p % (ht * vt) == 0) ? 1 : 0);
        check({t, ".border"}, bd, e_bd);
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) n <= 0;
        else     n <= n + 1;
    end

    always @(negedge clk) begin
        scan_model("A", 1, HA, HF, HS, HB, VA, VF, VS, VB, CS, BW, BH,
                   a_pen, a_col, a_row, a_cd, a_rd, a_act, a_hs, a_vs, a_fs, a_bd);
        scan_model("B", 4, HA, HF, HS, HB, VA, VF, VS, VB, CS, BW, BH,
                   b_pen, b_col, b_row, b_cd, b_rd, b_act, b_hs, b_vs, b_fs, b_bd);
        scan_model("C", 1, 640, 16, 96, 48, 480, 10, 2, 33, 4, 40, 30,
                   c_pen, c_col, c_row, c_cd, c_rd, c_act, c_hs, c_vs, c_fs, c_bd);
    end

    initial begin
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(200, 3000)) @(posedge clk);
            #($urandom_range(1, 3)) rst = 1'b1;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #($urandom_range(1, 3)) rst = 1'b0;
        end
        repeat (36000) @(posedge clk);
        @(negedge clk);
        #1 $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vga_board_scan.md
# vga_board_scan

Raster scan generator for the pong display path. Produces VGA sync, pixel counters and board-cell counters (`o_col_counter_div` / `o_row_counter_div`) consumed by the ball and paddle draw blocks. Those blocks compare these counters against object cell positions. Default timing is 640x480@60 with 16x16-pixel cells, giving a 40x30 board.

## Interface

**Parameters**
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP`, 16: horizontal front porch
- `H_SYNC`, 96: hsync width
- `H_BP`, 48: horizontal back porch
- `V_ACTIVE`, 480: visible lines
- `V_FP`, 10: vertical front porch
- `V_SYNC`, 2: vsync width
- `V_BP`, 33: vertical back porch
- `CELL_SHIFT`, 4: log2 of cell size in pixels
- `PIX_DIV`, 1: system clocks per pixel (1..16)
- `BOARD_WIDTH`, 40: board cells across
- `BOARD_HEIGHT`, 30: board cells down

**Ports**
- `clk` input 1: system clock
- `i_rst` input 1: asynchronous reset, active-high
- `o_pix_en` output 1: pixel strobe; counters advance on edges where it is 1
- `o_col_counter` output 10: pixel column, 0..H_TOTAL-1
- `o_row_counter` output 10: line, 0..V_TOTAL-1
- `o_col_counter_div` output 6: board column; 63 when not active
- `o_row_counter_div` output 6: board row; 63 when not active
- `o_active` output 1: visible region
- `o_hsync` output 1: active-low horizontal sync
- `o_vsync` output 1: active-low vertical sync
- `o_frame_start` output 1: one-pixel pulse at (0,0)
- `o_border` output 1: board edge cell (see Configuration)

## Operation

- H_TOTAL = sum of the H parameters (800); V_TOTAL = sum of the V parameters (525).
- Pixel divider:
  - Counts 0..PIX_DIV-1 every clock and wraps.
  - `o_pix_en` = (divider == PIX_DIV-1), decoded from the divider register. This is the only unregistered output.
  - With PIX_DIV=1, `o_pix_en` is constantly 1.
- Scan counters, on each edge where `o_pix_en`=1:
  - `o_col_counter` increments, wrapping H_TOTAL-1 to 0.
  - On that wrap, `o_row_counter` increments, wrapping V_TOTAL-1 to 0.
- All other outputs are registered. They are computed from the next counter values, so they always describe the currently presented (col,row) and hold for PIX_DIV clocks.
- `o_active` = col < H_ACTIVE and row < V_ACTIVE.
- Div counters:
  - Active: col >> CELL_SHIFT and row >> CELL_SHIFT, truncated to 6 bits.
  - Inactive: 6'h3F, so no draw block matches during blanking.
- `o_hsync` = 0 for col in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. 656..751.
- `o_vsync` = 0 for row in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. 490..491, for full lines.
- `o_frame_start` = 1 only while (col,row) = (0,0) is presented after a wrap from (H_TOTAL-1,V_TOTAL-1). It is not asserted for the post-reset (0,0).
- Reset values:
  - divider 0; counters 0; div counters 0.
  - `o_active`=1, `o_hsync`=1, `o_vsync`=1, `o_frame_start`=0, `o_border`=0.
  - `o_pix_en` = (PIX_DIV==1).
- Reset mid-frame: every register returns to its reset value asynchronously. The scan restarts from (0,0); no partial-line recovery.

## Timing

- First counter advance on rising edge PIX_DIV after reset release.
- Output-to-counter skew: zero. Sync, active, div, frame_start and border change on the same edge as the counters.
- Line period: H_TOTAL*PIX_DIV clocks. Frame period: H_TOTAL*V_TOTAL*PIX_DIV clocks.
- `o_frame_start` width: PIX_DIV clocks, once per frame.
- The row update and the col wrap occur on the same edge; no intermediate (0,old_row) state is visible.

## Configuration

- `VGA_BOARD_BORDER_EN` defined:
  - `o_border` = `o_active` and (div col == 0, or BOARD_WIDTH-1, or div row == 0, or BOARD_HEIGHT-1).
  - Registered and aligned with the other outputs.
- Not defined: `o_border` is tied to 0. The port remains present.

## Test plan

- Line timing, PIX_DIV=1, release reset:
  - col runs 0..799 then 0; row increments exactly at that wrap.
  - `o_hsync` low for exactly 96 pixels, cols 656..751.
- Frame timing:
  - `o_vsync` low for rows 490..491 only.
  - `o_frame_start` pulses once per 420000 pixels, at (0,0) after wrap; not at the post-reset (0,0).
- Div mapping:
  - col 15 → 0; col 16 → 1; col 639 → 39; col 640 → 63.
  - row 479 → 29; row 480 → 63.
  - `o_active` falls at col 640.
- PIX_DIV=4:
  - `o_pix_en` high 1 clock in 4.
  - Each counter value held 4 clocks; first advance on edge 4.
  - Line lasts 3200 clocks.
- Reset pulse mid-frame at (300,200):
  - All outputs at reset values before the next clock edge.
  - After release, scan resumes from (0,0) with timing identical to the first frame.
- `VGA_BOARD_BORDER_EN`:
  - `o_border`=1 at div (0,10), (39,10), (5,0), (5,29); 0 at (20,15) and in blanking.
  - Macro undefined: `o_border` is 0 for a full frame.
